// File: rtl/driver_dac.sv
// ============================================================================
//  Module   : driver_dac
//  Purpose  : Playback driver for an 8-bit parallel DAC. Accepts filtered
//             samples over a valid/ready handshake, buffers them in a small
//             FIFO, generates the divided DAC clock and presents one sample
//             per DAC period with half a period of setup before the rising
//             edge of clk_DAC. Flags underruns and holds DAC_En low until the
//             FIFO has been primed.
//  Options  : DRIVER_DAC_MIDSCALE_ON_UNDERRUN_EN - when defined, an underrun
//             tick drives midscale onto DAC_Data instead of holding the last
//             sample.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module driver_dac #(
    parameter int CLK_DIV     = 100,
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int PRIME_LEVEL = 8
) (
    input  logic                          clk_100MHz,
    input  logic                          Rst,
    input  logic [DATA_W-1:0]             Din,
    input  logic                          Din_Valid,
    output logic                          Din_Ready,
    output logic                          clk_DAC,
    output logic [DATA_W-1:0]             DAC_Data,
    output logic                          DAC_En,
    output logic                          Underrun,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_Level
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]  LVL_PRIME = LVL_W'(PRIME_LEVEL);
    localparam logic [DATA_W-1:0] MIDSCALE  = {1'b1, {(DATA_W-1){1'b0}}};

    localparam logic [0:0] ST_PRIME = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // ------------------------------------------------------------------
    // Internal state
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_next;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [0:0]        state;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    logic tick;
    logic fifo_empty;
    logic push;
    logic start;
    logic pop;
    logic underrun_evt;

    // ------------------------------------------------------------------
    // Divider next-count and event decode
    // ------------------------------------------------------------------
    always_comb begin
        div_next     = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        tick         = (div_cnt == DIV_LAST);
        fifo_empty   = (level == '0);
        push         = Din_Valid && Din_Ready;
        // Leaving PRIME needs enough buffered samples to ride out jitter
        // on the filter side; PRIME_LEVEL >= 1 so start implies non-empty.
        start        = tick && (state == ST_PRIME) && (level >= LVL_PRIME);
        // The pop only sees the level before this cycle's push, so a
        // sample written on a tick cycle is never consumed by that tick.
        pop          = tick && !fifo_empty && ((state == ST_RUN) || start);
        underrun_evt = tick && (state == ST_RUN) && fifo_empty;
    end

    assign Din_Ready  = (level != LVL_FULL);
    assign Fifo_Level = level;
    assign DAC_En     = (state == ST_RUN);

    // Free-running divider; clk_DAC is registered from the next count so it
    // is glitch-free and falls on the same edge that updates DAC_Data.
    always_ff @(posedge clk_100MHz or negedge Rst) begin
        if (!Rst) begin
            div_cnt <= '0;
            clk_DAC <= 1'b0;
        end else begin
            div_cnt <= div_next;
            clk_DAC <= (div_next >= DIV_HALF);
        end
    end

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_100MHz) begin
        if (push) begin
            mem[wr_ptr] <= Din;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the level.
    always_ff @(posedge clk_100MHz or negedge Rst) begin
        if (!Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // Playback state: PRIME until the FIFO is primed, then RUN for good.
    always_ff @(posedge clk_100MHz or negedge Rst) begin
        if (!Rst) begin
            state <= ST_PRIME;
        end else if (start) begin
            state <= ST_RUN;
        end
    end

    // DAC data register and underrun pulse, both updated one cycle after tick.
    always_ff @(posedge clk_100MHz or negedge Rst) begin
        if (!Rst) begin
            DAC_Data <= MIDSCALE;
            Underrun <= 1'b0;
        end else begin
            Underrun <= underrun_evt;
            if (pop) begin
                DAC_Data <= mem[rd_ptr];
            end
`ifdef DRIVER_DAC_MIDSCALE_ON_UNDERRUN_EN
            else if (underrun_evt) begin
                DAC_Data <= MIDSCALE;
            end
`else
            // On underrun the last sample is simply held.
`endif
        end
    end

endmodule

`default_nettype wire
